// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state encoding and constants for the PWM ramp sequencer
package pwm_pkg;
  typedef enum logic [2:0] {IDLE, LAUNCH, RAMP, DWELL, RETARGET, STOPPING} state_t;
  localparam int WIDTH_DEF = 4;
  localparam int MIN_PERIOD = 2;
endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// pwm_ramp_ctrl_if: ramp command valid/ready channel
interface pwm_ramp_ctrl_if #(parameter int WIDTH = pwm_pkg::WIDTH_DEF, parameter int HOLD_W = 4);
  logic cmd_valid;
  logic cmd_ready;
  logic [WIDTH-1:0] cmd_period;
  logic [WIDTH-1:0] cmd_duty;
  logic [WIDTH-1:0] cmd_step;
  logic [HOLD_W-1:0] cmd_hold;
  modport master(output cmd_valid, cmd_period, cmd_duty, cmd_step, cmd_hold, input cmd_ready);
  modport slave(input cmd_valid, cmd_period, cmd_duty, cmd_step, cmd_hold, output cmd_ready);
endinterface

// File: rtl/pwm_step_calc.sv
// pwm_step_calc: one saturating duty step toward the target, up or down
module pwm_step_calc #(parameter int WIDTH = 4) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] tgt,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] nxt
);
  logic [WIDTH:0] up;
  logic [WIDTH-1:0] gap;
  assign up = {1'b0, cur} + {1'b0, step};
  assign gap = cur - tgt;
  // step 0 jumps straight to the target; otherwise clamp so we never pass it
  assign nxt = step == '0 ? tgt :
               cur < tgt ? (up >= {1'b0, tgt} ? tgt : up[WIDTH-1:0]) :
               (step >= gap ? tgt : cur - step);
endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: sequences PWM period/duty ramps, updating only on period boundaries
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int HOLD_W = 4
) (
  input  logic clock,
  input  logic resetPWM_n,
  pwm_ramp_ctrl_if.slave cmd,
  input  logic stop,
  input  logic [WIDTH-1:0] pwm_count,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] duty,
  output logic startPWM,
  output logic busy,
  output logic done,
  output logic err
);
  state_t state, state_n;
  logic [WIDTH-1:0] period_n, duty_n, target, target_n, step, step_n, nxt_duty;
  logic [WIDTH-1:0] p_period, p_period_n, p_target, p_target_n, p_step, p_step_n;
  logic [WIDTH-1:0] cmd_tgt, cur_clip;
  logic [HOLD_W-1:0] hold, hold_n, p_hold, p_hold_n, hcnt, hcnt_n, cmd_h;
  logic start_n, done_n, err_n, stepped, stepped_n;
  logic boundary, bad, take;
  assign boundary = startPWM && (pwm_count == period - WIDTH'(1));
  assign bad = cmd.cmd_period < WIDTH'(MIN_PERIOD);
  assign cmd_tgt = cmd.cmd_duty > cmd.cmd_period ? cmd.cmd_period : cmd.cmd_duty;
  assign cmd_h = cmd.cmd_hold == '0 ? HOLD_W'(1) : cmd.cmd_hold;
  assign cur_clip = duty > p_period ? p_period : duty;
  assign cmd.cmd_ready = state == IDLE || state == DWELL;
  assign busy = state != IDLE;
  // stop outranks a same-cycle command except in IDLE, where stop means nothing
  assign take = cmd.cmd_valid && cmd.cmd_ready && (state == IDLE || !stop);
  pwm_step_calc #(.WIDTH(WIDTH)) u_step (.cur(duty), .tgt(target), .step(step), .nxt(nxt_duty));
  // next-state and datapath updates; stepped marks the cycle right after a duty write
  always_comb begin
    state_n = state;
    period_n = period;
    duty_n = duty;
    target_n = target;
    step_n = step;
    hold_n = hold;
    hcnt_n = hcnt;
    p_period_n = p_period;
    p_target_n = p_target;
    p_step_n = p_step;
    p_hold_n = p_hold;
    start_n = startPWM;
    done_n = 1'b0;
    err_n = take && bad;
    stepped_n = 1'b0;
    case (state)
      IDLE: if (take && !bad) begin
        period_n = cmd.cmd_period;
        target_n = cmd_tgt;
        step_n = cmd.cmd_step;
        hold_n = cmd_h;
        duty_n = '0;
        state_n = LAUNCH;
      end
      LAUNCH: if (stop) state_n = STOPPING;
      else begin
        start_n = 1'b1;
        hcnt_n = hold;
        state_n = RAMP;
      end
      RAMP: if (stop) state_n = STOPPING;
      else if (duty == target && (stepped || boundary)) begin
        done_n = 1'b1;
        state_n = DWELL;
      end else if (boundary) begin
        duty_n = hcnt <= HOLD_W'(1) ? nxt_duty : duty;
        hcnt_n = hcnt <= HOLD_W'(1) ? hold : hcnt - HOLD_W'(1);
        stepped_n = hcnt <= HOLD_W'(1);
      end
      DWELL: if (stop) state_n = STOPPING;
      else if (take && !bad) begin
        p_period_n = cmd.cmd_period;
        p_target_n = cmd_tgt;
        p_step_n = cmd.cmd_step;
        p_hold_n = cmd_h;
        state_n = RETARGET;
      end
      RETARGET: if (stop) state_n = STOPPING;
      else if (boundary) begin
        period_n = p_period;
        target_n = p_target;
        step_n = p_step;
        hold_n = p_hold;
        hcnt_n = p_hold;
        duty_n = cur_clip;
        state_n = RAMP;
      end
      STOPPING: if (boundary || !startPWM) begin
        duty_n = '0;
        start_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clock or negedge resetPWM_n)
    if (!resetPWM_n) begin
      state <= IDLE;
      period <= '0;
      duty <= '0;
      target <= '0;
      step <= '0;
      hold <= '0;
      hcnt <= '0;
      p_period <= '0;
      p_target <= '0;
      p_step <= '0;
      p_hold <= '0;
      startPWM <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      stepped <= 1'b0;
    end else begin
      state <= state_n;
      period <= period_n;
      duty <= duty_n;
      target <= target_n;
      step <= step_n;
      hold <= hold_n;
      hcnt <= hcnt_n;
      p_period <= p_period_n;
      p_target <= p_target_n;
      p_step <= p_step_n;
      p_hold <= p_hold_n;
      startPWM <= start_n;
      done <= done_n;
      err <= err_n;
      stepped <= stepped_n;
    end
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: scoreboard bench for the PWM ramp sequencer with a PWM counter model
module tb_pwm_ramp_ctrl;
  logic clock = 1'b0;
  logic resetPWM_n = 1'b0;
  logic stop = 1'b0;
  logic [3:0] pwm_count, period, duty;
  logic startPWM, busy, done, err;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_chg = 0;
  logic [3:0] prev_duty = '0;
  int exp_q[$];
  int chg_t[$];
  pwm_ramp_ctrl_if #(.WIDTH(4), .HOLD_W(4)) cmd_if ();
  pwm_ramp_ctrl #(.WIDTH(4), .HOLD_W(4)) dut (
    .clock(clock), .resetPWM_n(resetPWM_n), .cmd(cmd_if), .stop(stop), .pwm_count(pwm_count),
    .period(period), .duty(duty), .startPWM(startPWM), .busy(busy), .done(done), .err(err)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  // PWM counter: runs 0..period-1 while started
  always @(posedge clock or negedge resetPWM_n)
    if (!resetPWM_n) pwm_count <= '0;
    else pwm_count <= (!startPWM || pwm_count == period - 4'd1) ? 4'd0 : pwm_count + 4'd1;
  task automatic chk(input string tag, input int obs, input int want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, want);
    end
  endtask
  // each duty change is popped against the queue and must land on a count wrap
  always @(negedge clock) begin
    if (duty !== prev_duty) begin
      if (exp_q.size() == 0) chk("duty_extra", duty, prev_duty);
      else chk("duty_seq", duty, exp_q.pop_front());
      chk("duty_at_wrap", pwm_count, 0);
      chg_t.push_back(cyc);
      last_chg = cyc;
      prev_duty = duty;
    end
    if (done) begin
      done_cnt++;
      chk("done_timing", cyc - last_chg, 1);
    end
  end
  task automatic send(input int p, input int d, input int s, input int h);
    int t = 0;
    @(negedge clock);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_period = p[3:0];
    cmd_if.cmd_duty = d[3:0];
    cmd_if.cmd_step = s[3:0];
    cmd_if.cmd_hold = h[3:0];
    while (!cmd_if.cmd_ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (!cmd_if.cmd_ready) chk("send_ready", 0, 1);
    @(posedge clock);
    #1 cmd_if.cmd_valid = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    int s = done_cnt;
    int t = 0;
    while (done_cnt == s && t < 500) begin
      @(negedge clock);
      t++;
    end
    repeat (3) @(negedge clock);
    chk({tag, "_done"}, done_cnt - s, 1);
    chk({tag, "_q"}, exp_q.size(), 0);
  endtask
  task automatic do_stop(input string tag);
    int t = 0;
    exp_q.push_back(0);
    @(negedge clock);
    stop = 1'b1;
    while (startPWM && t < 20) begin
      @(negedge clock);
      t++;
    end
    stop = 1'b0;
    chk({tag, "_lat"}, int'(t <= 11), 1);
    @(negedge clock);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_duty"}, duty, 0);
  endtask
  initial begin
    int t;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_period = '0;
    cmd_if.cmd_duty = '0;
    cmd_if.cmd_step = '0;
    cmd_if.cmd_hold = '0;
    repeat (3) @(negedge clock);
    chk("rst_period", period, 0);
    chk("rst_duty", duty, 0);
    chk("rst_start", startPWM, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", cmd_if.cmd_ready, 1);
    resetPWM_n = 1'b1;
    // basic ramp up
    for (int i = 1; i <= 5; i++) exp_q.push_back(i);
    send(10, 5, 1, 1);
    @(negedge clock);
    chk("t1_busy", busy, 1);
    chk("t1_period", period, 10);
    chk("t1_start_lo", startPWM, 0);
    @(negedge clock);
    chk("t1_start_hi", startPWM, 1);
    wait_done("t1");
    chk("t1_start_kept", startPWM, 1);
    chk("t1_dwell_ready", cmd_if.cmd_ready, 1);
    // retarget downward with hold 2
    exp_q.push_back(3);
    exp_q.push_back(1);
    chg_t.delete();
    send(10, 1, 2, 2);
    wait_done("t2");
    chk("t2_changes", chg_t.size(), 2);
    if (chg_t.size() == 2) chk("t2_spacing", chg_t[1] - chg_t[0], 20);
    do_stop("s1");
    // short period is rejected
    send(1, 3, 1, 1);
    @(negedge clock);
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    chk("err_period", period, 10);
    @(negedge clock);
    chk("err_clear", err, 0);
    // target clipped to period
    exp_q.push_back(4);
    exp_q.push_back(8);
    send(8, 12, 4, 1);
    wait_done("clip");
    chk("clip_period", period, 8);
    chk("clip_duty", duty, 8);
    do_stop("s2");
    // step 0 jumps directly
    exp_q.push_back(7);
    send(10, 7, 0, 1);
    wait_done("jump");
    do_stop("s3");
    // stop with a same-cycle command mid-ramp
    send(10, 9, 1, 3);
    repeat (5) @(negedge clock);
    stop = 1'b1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_period = 4'd6;
    t = 0;
    while (startPWM && t < 20) begin
      @(negedge clock);
      t++;
    end
    stop = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    chk("sv_lat", int'(t <= 11), 1);
    @(negedge clock);
    chk("sv_period", period, 10);
    chk("sv_busy", busy, 0);
    chk("sv_duty", duty, 0);
    // asynchronous reset mid-ramp
    exp_q.push_back(1);
    exp_q.push_back(2);
    send(10, 9, 1, 1);
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clock);
      t++;
    end
    chk("ar_reach", exp_q.size(), 0);
    exp_q.push_back(0);
    @(negedge clock);
    #2 resetPWM_n = 1'b0;
    #1;
    chk("ar_period", period, 0);
    chk("ar_duty", duty, 0);
    chk("ar_start", startPWM, 0);
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_err", err, 0);
    chk("ar_ready", cmd_if.cmd_ready, 1);
    repeat (2) @(negedge clock);
    resetPWM_n = 1'b1;
    repeat (2) @(negedge clock);
    chk("final_q", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Sequencer for the `PWM` generator. It accepts ramp commands over a valid/ready handshake and drives the PWM's `period`, `duty` and `startPWM` inputs. Duty moves toward a target in fixed steps, and each step is held for a programmed number of PWM periods. All duty and period changes are applied only at PWM period boundaries, so the PWM output never glitches. It sits between the control/register logic and the `PWM` instance.

## Interface
Parameters:
- `WIDTH`, default 4: width of period, duty and PWM count.
- `HOLD_W`, default 4: width of the hold-count field.

Ports:
- `clock` in 1: single clock, all logic on the rising edge.
- `resetPWM_n` in 1: asynchronous active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_period` in WIDTH: PWM period, in clocks.
- `cmd_duty` in WIDTH: target duty.
- `cmd_step` in WIDTH: duty increment per step; 0 means jump directly to target.
- `cmd_hold` in HOLD_W: PWM periods per step; 0 is treated as 1.
- `stop` in 1: level; request shutdown.
- `pwm_count` in WIDTH: PWM `count` output, which runs 0..period-1 and wraps.
- `period` out WIDTH: to the PWM.
- `duty` out WIDTH: to the PWM.
- `startPWM` out 1: to the PWM.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when `duty` first equals the target.
- `err` out 1: one-cycle pulse when a command is rejected.

## Operation
- Reset values: `period`=0, `duty`=0, `startPWM`=0, `busy`=0, `done`=0, `err`=0, `cmd_ready`=1. State resets to IDLE.
- **Boundary:** `boundary = startPWM & (pwm_count == period-1)`. Any register update made on a boundary is seen by the PWM starting at count 0.
- **Command validation:**
  - `cmd_period` < 2: accept the command, drop it, and pulse `err`. State is unchanged.
  - `cmd_duty` > `cmd_period`: clip the target to `cmd_period`.
- **States:**
  - IDLE: `cmd_ready`=1.
    - Valid command: load `period`, target, step and hold; set `duty`=0; go to LAUNCH.
  - LAUNCH (1 cycle): set `startPWM`=1; load the hold counter; go to RAMP.
  - RAMP: `cmd_ready`=0.
    - On each boundary, decrement the hold counter.
    - When the counter reads 1 on a boundary, step `duty` toward the target by `step` and reload the counter.
    - Saturate at the target; never overshoot.
    - Arithmetic is done in WIDTH+1 bits so the sum cannot wrap.
    - When `duty` equals the target, pulse `done` and go to DWELL. A target equal to the current duty pulses `done` on the first boundary.
  - DWELL: `cmd_ready`=1.
    - Valid command: latch it as pending; go to RETARGET.
  - RETARGET: on the next boundary, apply the pending `period` and target, keep the current `duty` (clipped to the new period), reload the hold counter, and go to RAMP. Ramping down follows the same rules with subtraction, saturating at the target.
  - STOPPING: `cmd_ready`=0. On the next boundary, set `duty`=0 and `startPWM`=0, then go to IDLE the following cycle.
- **Stop handling:**
  - `stop` in LAUNCH, RAMP, DWELL or RETARGET goes to STOPPING.
  - `stop` has priority over a same-cycle `cmd_valid`; that command is not accepted.
  - `stop` in IDLE is ignored.
- **Mid-operation reset:** all outputs return to their reset values immediately and asynchronously; the pending command is discarded.

## Timing
- Command accepted in IDLE at cycle T:
  - `busy` and `period` are valid at T+1.
  - `startPWM` rises at T+2.
- First duty step: after `hold` boundaries.
- Full ramp length: ceil(target/step)·hold PWM periods.
- `done` is asserted in the cycle after the final duty update.
- Stop latency: at most `period`+1 clocks until `startPWM` falls.
- `cmd_ready` is combinational from state only; it never depends on `cmd_valid`.

## Structure
- A shared package `pwm_pkg` holds:
  - the state enum (IDLE, LAUNCH, RAMP, DWELL, RETARGET, STOPPING);
  - the `WIDTH` default;
  - the `MIN_PERIOD`=2 constant.
- One natural sub-module, `pwm_step_calc`: combinational saturating step toward the target (up or down), WIDTH+1 internal width.
- Benches instantiate `pwm_ramp_ctrl` together with the real `PWM` block.

## Test plan
- Reset, then command period=10, duty=5, step=1, hold=1 → `duty` reads 1,2,3,4,5 on consecutive boundaries; `done` pulses once; `startPWM` stays high.
- In DWELL, command period=10, duty=1, step=2, hold=2 → `duty` goes 5→3→1, changing every 2 periods, and only when `pwm_count` wraps 9→0.
- Command period=8, duty=12 → target is clipped to 8. Separately, command period=1 → `err` pulses, state stays IDLE, outputs unchanged.
- Command step=0, duty=7 → `duty`=7 after the first boundary, with `done` in the cycle following that update.
- Assert `stop` and `cmd_valid` together mid-ramp → command not accepted; `startPWM` falls within 11 clocks; `duty`=0; state IDLE.
- Assert `resetPWM_n` low mid-ramp, asynchronously between edges → all outputs are at reset values before the next clock edge.
